// File: rtl/stream_matrix_receiver.sv
// AXI-Stream sink that writes a NUM_ROWS x NUM_COLS matrix row-major through an
// element-write port, one element per handshake, with sticky TLAST checking.
module stream_matrix_receiver #(
  parameter int WIDTH    = 32,
  parameter int NUM_ROWS = 169,
  parameter int NUM_COLS = 3,
  localparam int ROW_ADDR_WIDTH = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int COL_ADDR_WIDTH = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      ds_next_data,
  input  logic [WIDTH-1:0]          ds_out,
  input  logic                      ds_valid,
  input  logic                      ds_last,
  output logic [ROW_ADDR_WIDTH-1:0] write_row_addr,
  output logic [COL_ADDR_WIDTH-1:0] write_col_addr,
  output logic [WIDTH-1:0]          write_data,
  output logic                      write_ready,
  output logic                      finished_loading,
  output logic                      last_error
);

  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

  localparam logic [ROW_ADDR_WIDTH-1:0] ROW_MAX = ROW_ADDR_WIDTH'(NUM_ROWS - 1);
  localparam logic [COL_ADDR_WIDTH-1:0] COL_MAX = COL_ADDR_WIDTH'(NUM_COLS - 1);

  state_t                    state;
  logic                      start_q;
  logic [ROW_ADDR_WIDTH-1:0] row_cnt;
  logic [COL_ADDR_WIDTH-1:0] col_cnt;

  logic start_rise;
  logic handshake;
  logic col_end;
  logic final_elem;

  assign start_rise   = start & ~start_q;
  assign ds_next_data = (state == RECEIVE);
  assign handshake    = ds_valid & ds_next_data;
  assign col_end      = (col_cnt == COL_MAX);
  assign final_elem   = col_end && (row_cnt == ROW_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      start_q          <= 1'b0;
      row_cnt          <= '0;
      col_cnt          <= '0;
      write_row_addr   <= '0;
      write_col_addr   <= '0;
      write_data       <= '0;
      write_ready      <= 1'b0;
      finished_loading <= 1'b0;
      last_error       <= 1'b0;
    end else begin
      start_q     <= start;
      write_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start_rise) begin
            row_cnt    <= '0;
            col_cnt    <= '0;
            last_error <= 1'b0;
            state      <= RECEIVE;
          end
        end
        RECEIVE: begin
          if (handshake) begin
            write_ready    <= 1'b1;
            write_row_addr <= row_cnt;
            write_col_addr <= col_cnt;
            write_data     <= ds_out;
            // Mismatched TLAST is only flagged; the element count alone ends the load.
            if (ds_last != final_elem) last_error <= 1'b1;
            if (final_elem) begin
              row_cnt          <= '0;
              col_cnt          <= '0;
              finished_loading <= 1'b1;
              state            <= DONE;
            end else if (col_end) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + ROW_ADDR_WIDTH'(1);
            end else begin
              col_cnt <= col_cnt + COL_ADDR_WIDTH'(1);
            end
          end
        end
        DONE: begin
          if (start_rise) begin
            row_cnt          <= '0;
            col_cnt          <= '0;
            finished_loading <= 1'b0;
            last_error       <= 1'b0;
            state            <= RECEIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_matrix_receiver.sv
// Directed bench for stream_matrix_receiver (3x2, 32-bit): expected writes are
// queued when a handshake is driven and popped when write_ready appears.
module tb_stream_matrix_receiver;

  localparam int WIDTH = 32;
  localparam int NR    = 3;
  localparam int NC    = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             ds_next_data;
  logic [WIDTH-1:0] ds_out;
  logic             ds_valid;
  logic             ds_last;
  logic [1:0]       write_row_addr;
  logic [0:0]       write_col_addr;
  logic [WIDTH-1:0] write_data;
  logic             write_ready;
  logic             finished_loading;
  logic             last_error;

  stream_matrix_receiver #(.WIDTH(WIDTH), .NUM_ROWS(NR), .NUM_COLS(NC)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .ds_next_data     (ds_next_data),
    .ds_out           (ds_out),
    .ds_valid         (ds_valid),
    .ds_last          (ds_last),
    .write_row_addr   (write_row_addr),
    .write_col_addr   (write_col_addr),
    .write_data       (write_data),
    .write_ready      (write_ready),
    .finished_loading (finished_loading),
    .last_error       (last_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              row;
    int              col;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  // Bench model of the receiver
  logic exp_ready, exp_fin, exp_err, exp_wr;
  int   m_row, m_col;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    wr_t w;
    @(posedge clk);
    #1;
    check("ds_next_data", 64'(ds_next_data), 64'(exp_ready));
    check("finished_loading", 64'(finished_loading), 64'(exp_fin));
    check("last_error", 64'(last_error), 64'(exp_err));
    check("write_ready", 64'(write_ready), 64'(exp_wr));
    if (write_ready) begin
      n_cmp++;
      assert (sb.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_write observed=%0d,%0d expected=none", write_row_addr, write_col_addr);
      end
      if (sb.size() != 0) begin
        w = sb.pop_front();
        check("write_row_addr", 64'(write_row_addr), 64'(w.row));
        check("write_col_addr", 64'(write_col_addr), 64'(w.col));
        check("write_data", 64'(write_data), 64'(w.data));
      end
    end
    exp_wr = 1'b0;
  endtask

  task automatic drive_word(input logic [WIDTH-1:0] data, input logic last);
    logic fin;
    wr_t  w;
    fin      = (m_row == NR - 1) && (m_col == NC - 1);
    ds_valid = 1'b1;
    ds_out   = data;
    ds_last  = last;
    w.row = m_row; w.col = m_col; w.data = data;
    sb.push_back(w);
    exp_wr = 1'b1;
    if (last != fin) exp_err = 1'b1;
    if (m_col == NC - 1) begin
      m_col = 0;
      m_row = m_row + 1;
    end else begin
      m_col = m_col + 1;
    end
    if (fin) begin
      exp_fin   = 1'b1;
      exp_ready = 1'b0;
    end
    cycle();
    ds_valid = 1'b0;
    ds_last  = 1'b0;
  endtask

  task automatic start_edge();
    start = 1'b0;
    cycle();
    start     = 1'b1;
    exp_ready = 1'b1;
    exp_fin   = 1'b0;
    exp_err   = 1'b0;
    m_row     = 0;
    m_col     = 0;
    cycle();
  endtask

  // early_idx: word index carrying a premature TLAST (-1 for none)
  task automatic load(input logic [WIDTH-1:0] base, input int early_idx,
                      input bit drop_last, input bit gaps);
    logic lst;
    start_edge();
    for (int k = 0; k < NR * NC; k++) begin
      if (gaps) begin
        for (int g = 0; g < 3; g++) begin
          if ($urandom_range(0, 1) == 0) break;
          cycle();
        end
      end
      lst = ((k == NR * NC - 1) && !drop_last) || (k == early_idx);
      drive_word(base + WIDTH'(k), lst);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic hold_done(input int n);
    ds_valid = 1'b1;
    ds_out   = 32'hBAD0_0000;
    for (int i = 0; i < n; i++) cycle();
    ds_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ds_valid = 1'b0; ds_last = 1'b0; ds_out = '0;
    exp_ready = 1'b0; exp_fin = 1'b0; exp_err = 1'b0; exp_wr = 1'b0;
    m_row = 0; m_col = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_row_addr", 64'(write_row_addr), 64'd0);
    check("rst_col_addr", 64'(write_col_addr), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);

    // Idle with pending upstream data and no start
    ds_valid = 1'b1;
    ds_out   = 32'hDEAD_BEEF;
    for (int i = 0; i < 20; i++) cycle();
    ds_valid = 1'b0;

    // Back-to-back load; start stays high through DONE
    load(32'h10, -1, 1'b0, 1'b0);
    hold_done(5);

    // Same load with random valid gaps
    load(32'h10, -1, 1'b0, 1'b1);
    hold_done(3);

    // Early TLAST on word 3: all words written, error sticks in DONE
    load(32'h40, 2, 1'b0, 1'b0);
    check("early_last_err", 64'(last_error), 64'd1);
    hold_done(4);

    // Missing TLAST on the final word
    load(32'h50, -1, 1'b1, 1'b0);
    check("missing_last_err", 64'(last_error), 64'd1);

    // Reload clears the flags and writes from (0,0) again
    load(32'h20, -1, 1'b0, 1'b0);
    check("reload_err_clear", 64'(last_error), 64'd0);

    // Reset after three handshakes, with a handshake in the reset cycle
    start_edge();
    for (int k = 0; k < 3; k++) drive_word(32'h60 + WIDTH'(k), 1'b0);
    rst       = 1'b1;
    start     = 1'b0;
    ds_valid  = 1'b1;
    ds_out    = 32'hFEED_F00D;
    exp_ready = 1'b0;
    exp_fin   = 1'b0;
    exp_err   = 1'b0;
    cycle();
    check("midrst_row_addr", 64'(write_row_addr), 64'd0);
    check("midrst_col_addr", 64'(write_col_addr), 64'd0);
    check("midrst_data", 64'(write_data), 64'd0);
    rst      = 1'b0;
    ds_valid = 1'b0;
    cycle();
    load(32'h30, -1, 1'b0, 1'b1);
    hold_done(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
